// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision multiplier exponent path.
package fpu_pkg;

    localparam int EXP_W   = 8;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef logic [EXP_W-1:0]        exp_t;
    typedef logic signed [EXP_W+1:0] exp_s_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic inv;
    } mul_flags_t;

endpackage

// File: rtl/exp_add9.sv
// Ripple-carry adder for two biased exponents; carry-out becomes the 9th sum bit.
module exp_add9
    import fpu_pkg::*;
(
    input  logic [EXP_W-1:0] a_i,
    input  logic [EXP_W-1:0] b_i,
    output logic [EXP_W:0]   sum_o
);

    logic [EXP_W:0]   carry;
    logic [EXP_W-1:0] bit_sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < EXP_W; i++) begin : g_fa
        logic half;
        assign half       = a_i[i] ^ b_i[i];
        assign bit_sum[i] = half ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & half);
    end

    assign sum_o = {carry[EXP_W], bit_sum};

endmodule

// File: rtl/fpu_mul_exp_stage.sv
// Two-stage valid/ready exponent and sign path of the FP multiplier: bias removal,
// normalisation increment, and overflow/underflow/special-operand classification.
module fpu_mul_exp_stage
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             norm_valid,
    output logic             norm_ready,
    input  logic             norm_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             sign_out,
    output logic             flag_of,
    output logic             flag_uf,
    output logic             flag_inv
);

    logic       s1_valid_q;
    exp_s_t     s1_e1_q;
    logic       s1_sign_q;
    logic       s1_inf_q;
    logic       s1_zero_q;

    logic       s2_valid_q;
    exp_t       exp_q;
    logic       sign_q;
    mul_flags_t flags_q;

    logic [EXP_W:0] sum9;
    exp_s_t         s1_e1_d;
    logic           s1_inf_d;
    logic           s1_zero_d;
    exp_s_t         e2;
    exp_t           exp_d;
    mul_flags_t     flags_d;

    logic accept;
    logic s1_advance;

    exp_add9 u_add (
        .a_i   (exp_a),
        .b_i   (exp_b),
        .sum_o (sum9)
    );

    assign s1_advance = s1_valid_q && norm_valid && (!s2_valid_q || out_ready);
    assign in_ready   = !s1_valid_q || s1_advance;
    assign norm_ready = s1_advance;
    assign accept     = in_valid && in_ready;

    // Denormal operands are flushed, so a zero exponent field means a zero operand.
    assign s1_e1_d   = exp_s_t'({1'b0, sum9}) - exp_s_t'(BIAS);
    assign s1_inf_d  = (exp_a == exp_t'(EXP_MAX)) || (exp_b == exp_t'(EXP_MAX));
    assign s1_zero_d = (exp_a == '0) || (exp_b == '0);

    always_comb begin
        e2      = s1_e1_q + exp_s_t'({{(EXP_W+1){1'b0}}, norm_inc});
        exp_d   = e2[EXP_W-1:0];
        flags_d = '0;
        if (s1_inf_q && s1_zero_q) begin
            exp_d       = exp_t'(EXP_MAX);
            flags_d.inv = 1'b1;
        end else if (s1_inf_q) begin
            exp_d = exp_t'(EXP_MAX);
        end else if (s1_zero_q) begin
            exp_d = '0;
        end else if (e2 >= exp_s_t'(EXP_MAX)) begin
            exp_d      = exp_t'(EXP_MAX);
            flags_d.of = 1'b1;
        end else if (e2 <= exp_s_t'(0)) begin
            exp_d      = '0;
            flags_d.uf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_e1_q    <= '0;
            s1_sign_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_e1_q    <= s1_e1_d;
            s1_sign_q  <= sign_a ^ sign_b;
            s1_inf_q   <= s1_inf_d;
            s1_zero_q  <= s1_zero_d;
        end else if (s1_advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Result registers only change on advance, so they hold steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            flags_q    <= '0;
        end else if (s1_advance) begin
            s2_valid_q <= 1'b1;
            exp_q      <= exp_d;
            sign_q     <= s1_sign_q;
            flags_q    <= flags_d;
        end else if (out_ready && s2_valid_q) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign exp_out   = exp_q;
    assign sign_out  = sign_q;
    assign flag_of   = flags_q.of;
    assign flag_uf   = flags_q.uf;
    assign flag_inv  = flags_q.inv;

endmodule

// File: tb/tb_fpu_mul_exp_stage.sv
// Randomized and directed bench for fpu_mul_exp_stage against a queue-based reference model.
module tb_fpu_mul_exp_stage;

    typedef struct {
        int ea;
        int eb;
        bit sa;
        bit sb;
        bit ni;
        int acc;
    } op_t;

    typedef struct {
        logic [11:0] val;
        int          acc;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] exp_a = '0;
    logic [7:0] exp_b = '0;
    logic       sign_a = 1'b0;
    logic       sign_b = 1'b0;
    logic       norm_valid = 1'b0;
    logic       norm_ready;
    logic       norm_inc = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] exp_out;
    logic       sign_out;
    logic       flag_of;
    logic       flag_uf;
    logic       flag_inv;

    op_t  stimQ[$];
    op_t  opQ[$];
    res_t resQ[$];

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    int nvMode     = 0;
    int orMode     = 0;
    bit gapEn      = 1'b0;
    bit latChk     = 1'b0;

    fpu_mul_exp_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .sign_a     (sign_a),
        .sign_b     (sign_b),
        .norm_valid (norm_valid),
        .norm_ready (norm_ready),
        .norm_inc   (norm_inc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .sign_out   (sign_out),
        .flag_of    (flag_of),
        .flag_uf    (flag_uf),
        .flag_inv   (flag_inv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs !== expv)
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, expv, cyc);
        else
            passCount++;
    endtask

    // Result packed as {sign, inv, uf, of, exp[7:0]}, computed with plain integer arithmetic.
    function automatic logic [11:0] refResult(input int ea, input int eb, input bit sa, input bit sb, input bit ni);
        int         e;
        bit         inf;
        bit         zero;
        logic [7:0] ex;
        bit         of;
        bit         uf;
        bit         inv;
        e    = ea + eb - 127 + int'(ni);
        inf  = (ea == 255) || (eb == 255);
        zero = (ea == 0) || (eb == 0);
        of = 0; uf = 0; inv = 0;
        if (inf && zero) begin ex = 8'd255; inv = 1; end
        else if (inf) ex = 8'd255;
        else if (zero) ex = 8'd0;
        else if (e >= 255) begin ex = 8'd255; of = 1; end
        else if (e <= 0) begin ex = 8'd0; uf = 1; end
        else ex = 8'(e);
        return {sa ^ sb, inv, uf, of, ex};
    endfunction

    task automatic applyStimulus(input int ea, input int eb, input bit sa, input bit sb, input bit ni);
        op_t o;
        o.ea = ea; o.eb = eb; o.sa = sa; o.sb = sb; o.ni = ni; o.acc = 0;
        stimQ.push_back(o);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int i;
        i = 0;
        while ((stimQ.size() + opQ.size() + resQ.size()) != 0 && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        checkOutput("drain_timeout", 32'(stimQ.size() + opQ.size() + resQ.size()), 32'd0);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_result", {sign_out, flag_inv, flag_uf, flag_of, exp_out}, 12'h000);
        stimQ.delete();
        opQ.delete();
        resQ.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Emulates the operand source, the mantissa unit and the downstream sink.
    always @(posedge clk) begin
        #1;
        if (stimQ.size() > 0 && (!gapEn || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            exp_a    = 8'(stimQ[0].ea);
            exp_b    = 8'(stimQ[0].eb);
            sign_a   = stimQ[0].sa;
            sign_b   = stimQ[0].sb;
        end else begin
            in_valid = 1'b0;
            exp_a    = 8'($urandom);
            exp_b    = 8'($urandom);
            sign_a   = 1'($urandom);
            sign_b   = 1'($urandom);
        end
        norm_valid = (nvMode == 0) ? 1'b1 : (nvMode == 1) ? 1'b0 : 1'($urandom_range(1));
        norm_inc   = (opQ.size() > 0) ? opQ[0].ni : 1'($urandom_range(1));
        out_ready  = (orMode == 0) ? 1'b1 : (orMode == 1) ? 1'b0 : ($urandom_range(2) != 0);
    end

    // Reference model: transfers decided by the handshake rules, results by refResult.
    always @(negedge clk) begin
        if (rst_n) begin
            bit   expNr;
            op_t  o;
            res_t r;
            expNr = (opQ.size() > 0) && norm_valid && (resQ.size() == 0 || out_ready);
            checkOutput("norm_ready", norm_ready, expNr);
            checkOutput("in_ready", in_ready, (opQ.size() == 0) || expNr);
            checkOutput("out_valid", out_valid, resQ.size() > 0);
            if (out_valid && out_ready && resQ.size() > 0) begin
                r = resQ.pop_front();
                checkOutput("result", {sign_out, flag_inv, flag_uf, flag_of, exp_out}, r.val);
                if (latChk)
                    checkOutput("latency", cyc, r.acc + 1);
            end
            if (norm_valid && norm_ready && opQ.size() > 0) begin
                o = opQ.pop_front();
                r.val = refResult(o.ea, o.eb, o.sa, o.sb, o.ni);
                r.acc = o.acc;
                resQ.push_back(r);
            end
            if (in_valid && in_ready && stimQ.size() > 0) begin
                o = stimQ.pop_front();
                o.acc = cyc + 1;
                opQ.push_back(o);
            end
        end
    end

    initial begin
        #23;
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_result", {sign_out, flag_inv, flag_uf, flag_of, exp_out}, 12'h000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        waitCycles(2);

        latChk = 1'b1;
        applyStimulus(127, 127, 0, 0, 0);
        waitDrain();
        latChk = 1'b0;

        applyStimulus(127, 127, 0, 0, 1);
        applyStimulus(128, 128, 0, 1, 0);
        applyStimulus(200, 200, 1, 1, 0);
        applyStimulus(10, 10, 0, 0, 0);
        applyStimulus(255, 0, 1, 0, 1);
        applyStimulus(255, 130, 0, 0, 0);
        applyStimulus(0, 200, 0, 1, 1);
        applyStimulus(191, 191, 0, 0, 1);
        applyStimulus(64, 63, 0, 0, 1);
        waitDrain();

        orMode = 1;
        applyStimulus(100, 30, 0, 0, 0);
        applyStimulus(140, 150, 1, 0, 1);
        applyStimulus(129, 2, 0, 1, 0);
        waitCycles(6);
        checkOutput("bp_in_ready", in_ready, 1'b0);
        checkOutput("bp_accepts", 32'(3 - stimQ.size()), 32'd2);
        orMode = 0;
        waitDrain();

        nvMode = 1;
        applyStimulus(120, 140, 1, 1, 1);
        waitCycles(4);
        checkOutput("nv_norm_ready", norm_ready, 1'b0);
        checkOutput("nv_in_ready", in_ready, 1'b0);
        checkOutput("nv_out_valid", out_valid, 1'b0);
        nvMode = 0;
        waitDrain();

        orMode = 1;
        applyStimulus(150, 150, 0, 0, 0);
        applyStimulus(90, 100, 1, 0, 1);
        waitCycles(4);
        pulseReset();
        orMode = 0;
        waitCycles(1);
        applyStimulus(130, 140, 0, 1, 1);
        waitDrain();

        nvMode = 2;
        orMode = 2;
        gapEn  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (stimQ.size() < 3) begin
                int ea;
                int eb;
                ea = ($urandom_range(9) == 0) ? 255 : ($urandom_range(9) == 0) ? 0 : int'($urandom_range(254, 1));
                eb = ($urandom_range(3) == 0) ? int'($urandom_range(160, 100)) : int'($urandom_range(255));
                applyStimulus(ea, eb, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            waitCycles(1);
        end
        nvMode = 0;
        orMode = 0;
        gapEn  = 1'b0;
        waitDrain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
